// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: decode-offer and ALU-issue bundle of the issue controller.
// master = decode/ALU side, slave = controller (dec_ready, alu_* driven by it).
interface alu_issue_ctrl_if;
    logic       dec_valid;
    logic       dec_ready;
    logic [9:0] dec_opcode;
    logic [6:0] dec_funct7;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;
    logic       dec_uses_rs2;
    logic       alu_issue;
    logic [9:0] alu_opcode;
    logic [4:0] alu_rd;

    modport master (
        output dec_valid, dec_opcode, dec_funct7,
        output dec_rs1, dec_rs2, dec_rd, dec_uses_rs2,
        input  dec_ready, alu_issue, alu_opcode, alu_rd
    );

    modport slave (
        input  dec_valid, dec_opcode, dec_funct7,
        input  dec_rs1, dec_rs2, dec_rd, dec_uses_rs2,
        output dec_ready, alu_issue, alu_opcode, alu_rd
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: one-entry in-order issue stage with a 32-bit pending-write
// scoreboard and divide serialisation (ALU busy DIV_LATENCY cycles per div/rem).
// Ports: clk, reset (async, active low), bus (alu_issue_ctrl_if.slave:
// dec_* offer, dec_ready, alu_issue/alu_opcode/alu_rd), wb_valid/wb_rd
// (retire), flush (drop held entry), busy, stall_cycles.
// Option macro ALU_ISSUE_WB_BYPASS_EN: a same-cycle writeback masks its own
// scoreboard bit in the hazard check, saving one RAW stall cycle.
module alu_issue_ctrl #(
    parameter int DIV_LATENCY = 33
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_ctrl_if.slave    bus,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic               flush,
    output logic               busy,
    output logic [31:0]        stall_cycles
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_LONG = 1'b1
    } state_t;

    localparam logic [7:0] LONG_LOAD = 8'(DIV_LATENCY - 1);

    state_t      state;
    logic [7:0]  cnt;

    logic        entry_valid;
    logic [9:0]  e_op;
    logic [6:0]  e_f7;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [4:0]  e_rd;
    logic        e_u2;

    logic [31:0] sb;
    logic [31:0] sb_chk;
    logic [31:0] sb_nxt;

    logic        e_writes;
    logic        e_long;
    logic        hazard;
    logic        issue;
    logic        accept;

    always_comb begin
        e_writes = !(e_op[6:0] == 7'h23 ||
                     e_op[6:0] == 7'h63 ||
                     e_op[6:0] == 7'h0F) && (e_rd != 5'd0);
        e_long = (e_op[6:0] == 7'h33 || e_op[6:0] == 7'h3B) &&
                 (e_f7 == 7'b0000001) && e_op[9];
    end

`ifdef ALU_ISSUE_WB_BYPASS_EN
    // A retiring register is already readable this cycle.
    assign sb_chk = sb & ~({32{wb_valid}} & (32'd1 << wb_rd));
`else
    assign sb_chk = sb;
`endif

    always_comb begin
        hazard = 1'b0;
        if (e_rs1 != 5'd0 && sb_chk[e_rs1])
            hazard = 1'b1;
        if (e_u2 && e_rs2 != 5'd0 && sb_chk[e_rs2])
            hazard = 1'b1;
        if (e_writes && sb_chk[e_rd])
            hazard = 1'b1;
    end

    assign issue          = entry_valid && !hazard && (state == S_RUN);
    assign bus.alu_issue  = issue;
    assign bus.alu_opcode = e_op;
    assign bus.alu_rd     = e_rd;
    // A long op keeps the slot closed in its issue cycle; the follower
    // enters during LONG instead.
    assign bus.dec_ready  = !entry_valid || (issue && !e_long);
    assign accept         = bus.dec_valid && bus.dec_ready && !flush;
    assign busy           = entry_valid || (state == S_LONG) || (|sb);

    // Clear first, then set, so a same-cycle set wins.
    always_comb begin
        sb_nxt = sb;
        if (wb_valid)
            sb_nxt[wb_rd] = 1'b0;
        if (issue && e_writes)
            sb_nxt[e_rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_valid <= 1'b0;
            e_op        <= '0;
            e_f7        <= '0;
            e_rs1       <= '0;
            e_rs2       <= '0;
            e_rd        <= '0;
            e_u2        <= 1'b0;
        end else if (flush) begin
            entry_valid <= 1'b0;
        end else if (accept) begin
            entry_valid <= 1'b1;
            e_op        <= bus.dec_opcode;
            e_f7        <= bus.dec_funct7;
            e_rs1       <= bus.dec_rs1;
            e_rs2       <= bus.dec_rs2;
            e_rd        <= bus.dec_rd;
            e_u2        <= bus.dec_uses_rs2;
        end else if (issue) begin
            entry_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (issue && e_long) begin
                        state <= S_LONG;
                        cnt   <= LONG_LOAD;
                    end
                end
                S_LONG: begin
                    // Leave as the count reaches zero so the next
                    // issue lands exactly DIV_LATENCY cycles later.
                    if (cnt <= 8'd1) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sb <= '0;
        else
            sb <= sb_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cycles <= '0;
        else if (entry_valid && !issue)
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random stimulus; a cycle-level reference
// model predicts issues into a queue that a separate monitor drains.
module tb_alu_issue_ctrl;

    localparam int LAT = 33;

    typedef struct packed {
        logic [9:0] op;
        logic [6:0] f7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u2;
    } ins_t;

    typedef struct {
        logic [9:0] op;
        logic [4:0] rd;
        longint     cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        busy;
    logic [31:0] stall_cycles;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.DIV_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    ins_t        held[$];
    bit [31:0]   pend;
    longint      cyc;
    longint      long_until;
    int unsigned stall_m;
    exp_t        sbq[$];
    longint      iss_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic ins_t mk(input logic [9:0] op, input logic [6:0] f7,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u2);
        ins_t i;
        i.op = op; i.f7 = f7; i.rs1 = rs1;
        i.rs2 = rs2; i.rd = rd; i.u2 = u2;
        return i;
    endfunction

    function automatic bit writes(input ins_t i);
        return !(i.op[6:0] == 7'h23 || i.op[6:0] == 7'h63 ||
                 i.op[6:0] == 7'h0F) && i.rd != 0;
    endfunction

    function automatic bit is_long(input ins_t i);
        return (i.op[6:0] == 7'h33 || i.op[6:0] == 7'h3B) &&
               i.f7 == 7'd1 && i.op[9];
    endfunction

    // Registers the instruction touches, checked against pending writes.
    function automatic bit hz(input ins_t i, input bit [31:0] m);
        bit [31:0] r;
        r = '0;
        r[i.rs1] = 1'b1;
        if (i.u2) r[i.rs2] = 1'b1;
        if (writes(i)) r[i.rd] = 1'b1;
        r[0] = 1'b0;
        return (r & m) != 0;
    endfunction

    // Reference model: one step per cycle at the falling edge.
    always @(negedge clk) begin : model
        bit [31:0] m;
        bit        iss;
        bit        rdy;
        ins_t      cur;
        if (reset) begin
            m = pend;
`ifdef ALU_ISSUE_WB_BYPASS_EN
            if (wb_valid) m[wb_rd] = 1'b0;
`endif
            iss = held.size() > 0 && cyc >= long_until && !hz(held[0], m);
            rdy = held.size() == 0 || (iss && !is_long(held[0]));
            chk("alu_issue", bus.alu_issue, iss);
            chk("dec_ready", bus.dec_ready, rdy);
            chk("busy", busy,
                held.size() > 0 || cyc < long_until || pend != 0);
            chk("stall_cycles", stall_cycles, stall_m);
            chk("scoreboard", dut.sb, pend);
            cur = mk(bus.dec_opcode, bus.dec_funct7, bus.dec_rs1,
                     bus.dec_rs2, bus.dec_rd, bus.dec_uses_rs2);
            if (iss)
                sbq.push_back('{held[0].op, held[0].rd, cyc});
            if (held.size() > 0 && !iss) stall_m++;
            if (wb_valid) pend[wb_rd] = 1'b0;
            if (iss) begin
                if (writes(held[0])) pend[held[0].rd] = 1'b1;
                if (is_long(held[0])) long_until = cyc + LAT;
                void'(held.pop_front());
            end
            if (flush) held.delete();
            else if (bus.dec_valid && rdy) held.push_back(cur);
            pend[0] = 1'b0;
            cyc++;
        end
    end

    // Monitor: every DUT issue consumes one predicted issue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            #2;
            if (bus.alu_issue) begin
                iss_cyc.push_back(cyc - 1);
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_issue: got op %0h rd %0d expected none",
                             bus.alu_opcode, bus.alu_rd);
                end else begin
                    e = sbq.pop_front();
                    chk("issue_op", bus.alu_opcode, e.op);
                    chk("issue_rd", bus.alu_rd, e.rd);
                    chk("issue_cycle", cyc - 1, e.cyc);
                end
            end
        end
    end

    task automatic drive(input bit dv, input ins_t i, input bit wv,
                         input logic [4:0] wr, input bit fl);
        @(posedge clk);
        #1;
        bus.dec_valid    = dv;
        bus.dec_opcode   = i.op;
        bus.dec_funct7   = i.f7;
        bus.dec_rs1      = i.rs1;
        bus.dec_rs2      = i.rs2;
        bus.dec_rd       = i.rd;
        bus.dec_uses_rs2 = i.u2;
        wb_valid         = wv;
        wb_rd            = wr;
        flush            = fl;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, '0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic wb(input logic [4:0] r);
        drive(1'b0, '0, 1'b1, r, 1'b0);
    endtask

    task automatic model_reset();
        held.delete();
        sbq.delete();
        pend       = '0;
        cyc        = 0;
        long_until = 0;
        stall_m    = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_dec_ready", bus.dec_ready, 1'b1);
        chk("rst_alu_issue", bus.alu_issue, 1'b0);
        chk("rst_alu_opcode", bus.alu_opcode, 10'h0);
        chk("rst_alu_rd", bus.alu_rd, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_sb", dut.sb, 32'd0);
        chk("rst_cnt", dut.cnt, 8'd0);
    endtask

    function automatic ins_t rnd_ins();
        ins_t i;
        int   k;
        k = $urandom_range(0, 15);
        i = mk(10'h013, 7'd0, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)));
        i.op[9:7] = 3'($urandom_range(0, 7));
        if (k == 0) begin
            i.op[6:0] = ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h3B;
            i.op[9:7] = 3'($urandom_range(4, 7));
            i.f7 = 7'd1;
        end else if (k == 1) i.op[6:0] = 7'h23;
        else if (k == 2) i.op[6:0] = 7'h63;
        else if (k == 3) i.op[6:0] = 7'h0F;
        else if (k < 8) begin
            i.op[6:0] = 7'h33;
            i.f7 = 7'($urandom_range(0, 1));
        end
        return i;
    endfunction

    localparam ins_t NOP = '0;

    initial begin : main
        longint s0;
        longint wbc;
        int     gap;
        bit     wv;
        logic [4:0] wr;
        reset = 1'b0;
        bus.dec_valid = 1'b0;
        bus.dec_opcode = '0; bus.dec_funct7 = '0;
        bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
        bus.dec_uses_rs2 = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Two independent ADDIs issue back to back.
        drive(1, mk(10'h013, 0, 0, 0, 1, 0), 0, 0, 0);
        drive(1, mk(10'h013, 0, 0, 0, 2, 0), 0, 0, 0);
        idle(2);
        #1;
        chk("addi_pair_sb", dut.sb, 32'h6);
        chk("addi_pair_stall", stall_cycles, 32'd0);
        chk("addi_pair_gap", iss_cyc[$] - iss_cyc[$-1], 1);
        wb(1); wb(2);

        // RAW dependency resolved by writeback.
        s0 = stall_cycles;
        drive(1, mk(10'h013, 0, 0, 0, 5, 0), 0, 0, 0);
        drive(1, mk(10'h033, 0, 5, 5, 6, 1), 0, 0, 0);
        idle(2);
        wb(5);
        wbc = cyc;
        idle(2);
        #1;
`ifdef ALU_ISSUE_WB_BYPASS_EN
        chk("raw_issue_cycle", iss_cyc[$], wbc);
        chk("raw_stall", stall_cycles - s0, 2);
`else
        chk("raw_issue_cycle", iss_cyc[$], wbc + 1);
        chk("raw_stall", stall_cycles - s0, 3);
`endif
        wb(6);

        // DIV blocks the following ADD for the full latency.
        drive(1, mk(10'h233, 7'd1, 0, 0, 3, 0), 0, 0, 0);
        drive(1, mk(10'h033, 0, 8, 9, 7, 1), 0, 0, 0);
        drive(1, mk(10'h033, 0, 8, 9, 7, 1), 0, 0, 0);
        idle(36);
        gap = int'(iss_cyc[$] - iss_cyc[$-1]);
        chk("div_gap", gap, LAT);
        wb(3); wb(7);

        // Set and clear of the same bit in one cycle: set wins.
        drive(1, mk(10'h013, 0, 0, 0, 4, 0), 0, 0, 0);
        drive(0, NOP, 1, 4, 0);
        idle(1);
        #1;
        chk("set_wins", dut.sb[4], 1'b1);
        wb(4);

        // Flush of a hazard-held entry with a concurrent offer.
        drive(1, mk(10'h013, 0, 0, 0, 10, 0), 0, 0, 0);
        drive(1, mk(10'h033, 0, 10, 0, 11, 0), 0, 0, 0);
        drive(1, mk(10'h013, 0, 0, 0, 12, 0), 0, 0, 1);
        idle(1);
        #1;
        chk("flush_entry", dut.entry_valid, 1'b0);
        chk("flush_ready", bus.dec_ready, 1'b1);
        chk("flush_no_issue", bus.alu_issue, 1'b0);
        wb(10);
        idle(2);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            wv = 1'b0;
            wr = '0;
            if (pend != 0 && $urandom_range(0, 2) == 0) begin
                do wr = 5'($urandom_range(1, 31)); while (!pend[wr]);
                wv = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                wv = 1'b1;
                wr = 5'($urandom_range(0, 31));
            end
            drive($urandom_range(0, 3) != 0, rnd_ins(), wv, wr,
                  $urandom_range(0, 19) == 0);
        end

        // Drain, bounded.
        for (int n = 0; n < 300; n++) begin
            if (pend == 0 && held.size() == 0 &&
                cyc >= long_until && sbq.size() == 0)
                break;
            wv = 1'b0;
            wr = '0;
            for (int r = 1; r < 32; r++)
                if (pend[r] && !wv) begin
                    wv = 1'b1;
                    wr = 5'(r);
                end
            drive(1'b0, NOP, wv, wr, 1'b0);
        end
        idle(2);
        chk("drain_queue", sbq.size(), 0);
        chk("drain_sb", dut.sb, 32'd0);

        // Asynchronous reset in the middle of a long op.
        drive(1, mk(10'h233, 7'd1, 0, 0, 3, 0), 0, 0, 0);
        idle(6);
        chk("pre_reset_busy", busy, 1'b1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_reset_outputs();
        chk("rst_fsm_run", dut.state, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1, mk(10'h013, 0, 0, 0, 1, 0), 0, 0, 0);
        idle(2);
        wb(1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

In-order issue controller sitting between decode and the `alu` execute stage. Holds one decoded instruction, checks its source and destination registers against a 32-entry pending-write scoreboard, and issues it to the ALU when it is hazard-free. It also serialises long-latency divide/remainder operations by blocking further issue for a fixed number of cycles.

## Interface
- `DIV_LATENCY`, 33: ALU occupancy in cycles for DIV/DIVU/REM/REMU and their W forms; legal range 2..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decode offers an instruction.
- `dec_ready`  out  1  controller accepts the offer this cycle.
- `dec_opcode`  in  10  {funct3, opcode[6:0]}, same encoding as the ALU opcode.
- `dec_funct7`  in  7  instruction bits [31:25].
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  register indices.
- `dec_uses_rs2`  in  1  instruction reads rs2.
- `wb_valid`  in  1  writeback retires a result.
- `wb_rd`  in  5  register retired by writeback.
- `flush`  in  1  drop the held (not yet issued) instruction.
- `alu_issue`  out  1  one-cycle pulse; the ALU captures `alu_opcode` and `alu_rd` on this cycle.
- `alu_opcode`  out  10  opcode of the held entry.
- `alu_rd`  out  5  rd of the held entry.
- `busy`  out  1  entry held, or a long op in flight, or any scoreboard bit set.
- `stall_cycles`  out  32  count of cycles with an entry held but not issued.

## Operation
- **Entry register:** one slot holding {opcode, funct7, rs1, rs2, rd, uses_rs2}.
  - Loaded when `dec_valid && dec_ready && !flush`.
  - `dec_ready = !entry_valid || (alu_issue && !issue_is_long)`.
- **Writes rd:** true unless opcode[6:0] is 0x23 (store), 0x63 (branch) or 0x0F (fence), and rd != 0.
- **Hazard:** `sb[rs1]`, or `uses_rs2 && sb[rs2]`, or (writes rd && `sb[rd]`). x0 never hazards.
- **Long op:** opcode[6:0] is 0x33 or 0x3B, funct7 == 7'b0000001, and funct3[2] == 1.
- **FSM:**
  - IDLE/RUN: issue when `entry_valid && !hazard`. A long op issued here moves to LONG and loads the counter with DIV_LATENCY-1.
  - LONG: `alu_issue` is held at 0. The counter decrements each cycle; at 0 the FSM returns to RUN. An entry may be accepted while in LONG and stays held.
- **Scoreboard (`sb[31:0]`):**
  - Bit rd is set on issue when the instruction writes rd.
  - Bit `wb_rd` is cleared on `wb_valid`.
  - If set and clear hit the same register in one cycle, the set wins.
  - Bit 0 is always 0.
- **flush:**
  - Clears `entry_valid` and ignores a same-cycle `dec_valid`.
  - Does not abort LONG or change the scoreboard; issued ops are older than the flush point.
- **`stall_cycles`:** increments when `entry_valid && !alu_issue`; wraps from 2^32-1 to 0.

## Timing
- Reset values:
  - `entry_valid`=0, FSM=RUN, counter=0, `sb`=0.
  - `dec_ready`=1, `alu_issue`=0, `alu_opcode`=0, `alu_rd`=0, `busy`=0, `stall_cycles`=0.
- Reset asserted mid-operation returns every register to its reset value immediately; an in-flight long op is forgotten.
- `alu_issue`, `alu_opcode` and `alu_rd` are combinational from the entry, scoreboard and FSM state. No combinational path from `dec_*` to `alu_*`.
- Latency from acceptance to issue is 1 cycle when hazard-free. Sustained throughput is 1 instruction per cycle for back-to-back independent ops.
- A dependent op behind a producer issues in the cycle after the producer's `wb_valid` (base build).
- After a long op issues at cycle N, the next issue occurs no earlier than cycle N+DIV_LATENCY.
- An op issued while `flush` is high is still issued; the flush removes only what was held and not issued.

## Configuration
- `ALU_ISSUE_WB_BYPASS_EN` defined:
  - The hazard check uses `sb & ~({32{wb_valid}} & (1<<wb_rd))`.
  - A consumer can issue in the same cycle its producer writes back (RAW stall reduced by one cycle).
- `ALU_ISSUE_WB_BYPASS_EN` not defined:
  - The hazard check uses the registered `sb` only.

## Test plan
- Reset release, then ADDI x1 (0x013) followed by ADDI x2: issue in consecutive cycles; `sb`=0x6 after both issue; `stall_cycles`=0.
- ADDI x5, then ADD x6,x5,x5 with `wb_valid`/`wb_rd`=5 three cycles later:
  - Consumer issues 1 cycle after writeback (base build).
  - Consumer issues on the writeback cycle with `ALU_ISSUE_WB_BYPASS_EN`.
  - `stall_cycles` advances accordingly.
- DIV x3 (0x233, funct7=1) with DIV_LATENCY=33, then ADD x7,x8,x9 at cycle 1:
  - The ADD is accepted but `alu_issue` stays 0 for 32 cycles.
  - The ADD issues exactly 33 cycles after the DIV.
- Same-cycle issue of ADDI x4 and `wb_valid`/`wb_rd`=4: `sb[4]` ends at 1.
- Entry held on a hazard, then `flush`=1 together with `dec_valid`=1:
  - `entry_valid`=0 next cycle, no issue, new offer not captured.
  - `dec_ready`=1.
- `reset` driven low asynchronously during LONG with `sb`≠0: all outputs are at reset values before the next clock edge, and the FSM is in RUN.
